// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard receiver. The raw keyboard clock is synchronised and filtered
// in the system clock domain. Frames are checked for start, parity and stop
// bits, E0/F0 prefixes are folded into key events, and the events are queued
// in a first-word-fall-through FIFO with a valid/ready handshake.
module ps2_key_event_rx #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 8,
    localparam int AW            = $clog2(FIFO_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          kb_clock,
    input  logic          kb_data,
    input  logic          ev_ready,
    input  logic          clr_ovf,
    output logic          ev_valid,
    output logic [7:0]    ev_code,
    output logic          ev_release,
    output logic          ev_extended,
    output logic          frame_err,
    output logic          overflow,
    output logic [AW:0]   fifo_count
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_REL = 8'hF0;

    // input conditioning
    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic          filt_clk_q, filt_clk_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          fall_q, fall_d;

    // frame receiver
    logic [1:0]    state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          byte_done_q, byte_done_d;
    logic          frame_err_q, frame_err_d;

    // prefix folding
    logic          rel_q, rel_d;
    logic          ext_q, ext_d;
    logic          push_req;

    // event FIFO
    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [9:0]    last_q, last_d;
    logic [9:0]    head, wdata;
    logic          do_push, do_pop, full, drop;

    // Two-flop synchronisers; idle-high so a reset does not look like a clock edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= kb_clock;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= kb_data;
            dat_s2_q <= dat_s1_q;
        end
    end

    // Glitch filter: the filtered clock follows only after FILTER_LEN stable cycles
    always_comb begin
        filt_cnt_d = '0;
        filt_clk_d = filt_clk_q;
        if (clk_s2_q != filt_clk_q) begin
            if (filt_cnt_q == FILT_LAST) begin
                filt_clk_d = clk_s2_q;
            end else begin
                filt_cnt_d = filt_cnt_q + FW'(1);
            end
        end
        fall_d = filt_clk_q & ~filt_clk_d;
    end

    // Filter state and the registered falling-edge strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_clk_q <= 1'b1;
            filt_cnt_q <= '0;
            fall_q     <= 1'b0;
        end else begin
            filt_clk_q <= filt_clk_d;
            filt_cnt_q <= filt_cnt_d;
            fall_q     <= fall_d;
        end
    end

    // Frame FSM: one step per falling edge, plus the stalled-frame timeout
    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shreg_d     = shreg_q;
        par_d       = par_q;
        to_cnt_d    = to_cnt_q;
        byte_done_d = 1'b0;
        frame_err_d = 1'b0;
        if (fall_q) begin
            to_cnt_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (!dat_s2_q) begin
                        state_d  = ST_DATA;
                        bitcnt_d = 3'd0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                ST_DATA: begin
                    shreg_d = {dat_s2_q, shreg_q[7:1]};
                    if (bitcnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end
                ST_PARITY: begin
                    par_d   = dat_s2_q;
                    state_d = ST_STOP;
                end
                default: begin
                    // odd parity: total ones over data and parity must be odd
                    if (dat_s2_q && (^{shreg_q, par_q})) begin
                        byte_done_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            endcase
        end else if (state_q == ST_IDLE) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == TO_LAST) begin
            to_cnt_d    = '0;
            state_d     = ST_IDLE;
            frame_err_d = 1'b1;
        end else begin
            to_cnt_d = to_cnt_q + TW'(1);
        end
    end

    // Frame FSM registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bitcnt_q    <= 3'd0;
            shreg_q     <= 8'h00;
            par_q       <= 1'b0;
            to_cnt_q    <= '0;
            byte_done_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            par_q       <= par_d;
            to_cnt_q    <= to_cnt_d;
            byte_done_q <= byte_done_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Prefix folding and FIFO bookkeeping; shreg_q is stable while the FSM idles
    always_comb begin
        rel_d    = rel_q;
        ext_d    = ext_q;
        push_req = byte_done_q && (shreg_q != CODE_EXT) && (shreg_q != CODE_REL);
        if (frame_err_q) begin
            rel_d = 1'b0;
            ext_d = 1'b0;
        end else if (byte_done_q) begin
            if (shreg_q == CODE_EXT) begin
                ext_d = 1'b1;
            end else if (shreg_q == CODE_REL) begin
                rel_d = 1'b1;
            end else begin
                rel_d = 1'b0;
                ext_d = 1'b0;
            end
        end

        wdata   = {shreg_q, rel_q, ext_q};
        head    = mem_q[rd_ptr_q];
        full    = (count_q == DEPTH_CNT);
        do_pop  = ev_valid && ev_ready;
        do_push = push_req && (!full || do_pop);
        drop    = push_req && full && !do_pop;

        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase

        // a drop in the same cycle as clr_ovf keeps the flag set
        ovf_d  = drop | (ovf_q & ~clr_ovf);
        last_d = ev_valid ? head : last_q;
    end

    // Prefix flags, FIFO pointers, overflow flag and held output value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rel_q    <= 1'b0;
            ext_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            last_q   <= '0;
        end else begin
            rel_q    <= rel_d;
            ext_q    <= ext_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            last_q   <= last_d;
        end
    end

    // Event storage; contents are meaningless until counted, so no reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign ev_valid = (count_q != '0);
    assign {ev_code, ev_release, ev_extended} = ev_valid ? head : last_q;
    assign frame_err  = frame_err_q;
    assign overflow   = ovf_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_ps2_key_event_rx.sv
// Testbench for ps2_key_event_rx: drives PS/2 frames on the raw pins and
// compares every output each cycle with an event-level model.
module tb_ps2_key_event_rx;

    localparam int L = 4;
    localparam int T = 600;
    localparam int D = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       kb_clock = 1'b1;
    logic       kb_data = 1'b1;
    logic       ev_ready = 1'b0;
    logic       clr_ovf = 1'b0;
    logic       ev_valid;
    logic [7:0] ev_code;
    logic       ev_release;
    logic       ev_extended;
    logic       frame_err;
    logic       overflow;
    logic [3:0] fifo_count;

    ps2_key_event_rx #(.FILTER_LEN(L), .TIMEOUT_CYCLES(T), .FIFO_DEPTH(D)) dut (
        .clk(clk), .reset(reset), .kb_clock(kb_clock), .kb_data(kb_data),
        .ev_ready(ev_ready), .clr_ovf(clr_ovf), .ev_valid(ev_valid),
        .ev_code(ev_code), .ev_release(ev_release), .ev_extended(ev_extended),
        .frame_err(frame_err), .overflow(overflow), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit run_cmp  = 1'b0;
    bit mask_err = 1'b0;
    int fixed_lo = 0;

    // kind 0: byte arrives at the decoder, 1: frame error, 2: prefix clear only
    typedef struct {
        int         at;
        int         kind;
        logic [7:0] b;
    } sched_t;

    sched_t     sched[$];
    logic [9:0] m_fifo[$];
    bit         m_rel, m_ext, m_ovf, m_err;
    logic [9:0] m_last = '0;
    logic [9:0] exp_h;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Event-level model, stepped on every rising clock edge
    always @(posedge clk) begin
        sched_t e;
        bit     drop;
        cyc++;
        m_err = 1'b0;
        drop  = 1'b0;
        if (reset) begin
            m_fifo.delete();
            sched.delete();
            m_rel  = 1'b0;
            m_ext  = 1'b0;
            m_ovf  = 1'b0;
            m_last = '0;
        end else begin
            if (m_fifo.size() > 0) m_last = m_fifo[0];
            if (m_fifo.size() > 0 && ev_ready) void'(m_fifo.pop_front());
            while (sched.size() > 0 && sched[0].at <= cyc) begin
                e = sched.pop_front();
                if (e.kind == 0) begin
                    if (e.b == 8'hE0) m_ext = 1'b1;
                    else if (e.b == 8'hF0) m_rel = 1'b1;
                    else begin
                        if (m_fifo.size() < D) m_fifo.push_back({e.b, m_rel, m_ext});
                        else drop = 1'b1;
                        m_rel = 1'b0;
                        m_ext = 1'b0;
                    end
                end else begin
                    if (e.kind == 1) m_err = 1'b1;
                    m_rel = 1'b0;
                    m_ext = 1'b0;
                end
            end
            if (clr_ovf) m_ovf = 1'b0;
            if (drop) m_ovf = 1'b1;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (run_cmp && !reset) begin
            check("ev_valid", 32'(ev_valid), 32'(m_fifo.size() > 0));
            check("fifo_count", 32'(fifo_count), 32'(m_fifo.size()));
            check("overflow", 32'(overflow), 32'(m_ovf));
            if (!mask_err) check("frame_err", 32'(frame_err), 32'(m_err));
            exp_h = (m_fifo.size() > 0) ? m_fifo[0] : m_last;
            check("ev_code", 32'(ev_code), 32'(exp_h[9:2]));
            check("ev_release", 32'(ev_release), 32'(exp_h[1]));
            check("ev_extended", 32'(ev_extended), 32'(exp_h[0]));
        end
    end

    // Drives nbits of a frame (11 = complete); returns the cycle of the last raw fall
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int nbits, output int last_fall);
        logic [10:0] bits;
        int h, lo;
        sched_t e;
        bits = {1'b1 ^ bad_stop, ~(^b) ^ bad_par, b, 1'b0};
        last_fall = 0;
        for (int i = 0; i < nbits; i++) begin
            h  = int'($urandom_range(L + 5, L + 1));
            lo = (fixed_lo != 0) ? fixed_lo : int'($urandom_range(L + 5, L + 1));
            @(negedge clk);
            kb_data = bits[i];
            repeat (h) @(negedge clk);
            kb_clock  = 1'b0;
            last_fall = cyc;
            if (i == 10) begin
                e.b = b;
                if (bad_par || bad_stop) begin
                    e.at = cyc + 3 + L; e.kind = 1;
                end else begin
                    e.at = cyc + 4 + L; e.kind = 0;
                end
                sched.push_back(e);
            end
            repeat (lo) @(negedge clk);
            kb_clock = 1'b1;
        end
        @(negedge clk);
        kb_data = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        int f;
        send_frame(b, 1'b0, 1'b0, 11, f);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pop();
        ev_ready = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0;
    endtask

    task automatic expect_head(input string nm, input logic [7:0] c, input bit r, input bit x);
        int k;
        k = 0;
        while (!ev_valid && k < 60) begin
            @(negedge clk);
            k++;
        end
        check({nm, "_valid"}, 32'(ev_valid), 32'(1));
        check({nm, "_code"}, 32'(ev_code), 32'(c));
        check({nm, "_rel"}, 32'(ev_release), 32'(r));
        check({nm, "_ext"}, 32'(ev_extended), 32'(x));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] codes [9];
        int c, cnt;
        bit rnd_done;
        codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};

        // asynchronous reset, checked before any clock edge
        #1 reset = 1'b1;
        #1;
        check("rst_valid", 32'(ev_valid), 32'(0));
        check("rst_code", 32'(ev_code), 32'(0));
        check("rst_count", 32'(fifo_count), 32'(0));
        check("rst_ovf", 32'(overflow), 32'(0));
        check("rst_err", 32'(frame_err), 32'(0));
        settle(3);
        reset   = 1'b0;
        run_cmp = 1'b1;
        settle(5);

        // 1: single make code with exact latency
        fixed_lo = L + 1;
        send_frame(8'h1C, 1'b0, 1'b0, 11, c);
        fixed_lo = 0;
        wait_until(c + L + 3);
        check("t1_valid_early", 32'(ev_valid), 32'(0));
        @(negedge clk);
        check("t1_valid", 32'(ev_valid), 32'(1));
        check("t1_code", 32'(ev_code), 32'(8'h1C));
        check("t1_flags", 32'({ev_release, ev_extended}), 32'(0));
        check("t1_count", 32'(fifo_count), 32'(1));
        pop();
        check("t1_count_after_pop", 32'(fifo_count), 32'(0));
        check("t1_hold_code", 32'(ev_code), 32'(8'h1C));

        // 2: prefix folding
        send(8'hF0); send(8'h1C);
        expect_head("t2_break", 8'h1C, 1'b1, 1'b0);
        check("t2_count", 32'(fifo_count), 32'(1));
        pop();
        send(8'hE0); send(8'hF0); send(8'h75);
        expect_head("t2_ext_break", 8'h75, 1'b1, 1'b1);
        pop();
        send(8'h1C);
        expect_head("t2_make", 8'h1C, 1'b0, 1'b0);
        pop();

        // 3: parity and stop errors
        send_frame(8'h1C, 1'b1, 1'b0, 11, c);
        settle(6);
        check("t3_no_event", 32'(fifo_count), 32'(0));
        send(8'hF0);
        send_frame(8'h33, 1'b0, 1'b1, 11, c);
        send(8'h1C);
        expect_head("t3_after_err", 8'h1C, 1'b0, 1'b0);
        pop();

        // 4: timeout after five bits, then glitch rejection
        send(8'hF0);
        send_frame(8'h15, 1'b0, 1'b0, 5, c);
        sched.push_back('{c + L + T + 3, 2, 8'h00});
        wait_until(c + L + T - 5);
        mask_err = 1'b1;
        cnt = 0;
        repeat (16) begin
            @(negedge clk);
            if (frame_err) cnt++;
        end
        mask_err = 1'b0;
        check("t4_timeout_pulses", 32'(cnt), 32'(1));
        @(negedge clk);
        kb_clock = 1'b0;
        repeat (L - 1) @(negedge clk);
        kb_clock = 1'b1;
        cnt = 0;
        repeat (2 * L + 10) begin
            @(negedge clk);
            if (frame_err) cnt++;
        end
        check("t4_glitch_pulses", 32'(cnt), 32'(0));
        send(8'h15);
        expect_head("t4_after_timeout", 8'h15, 1'b0, 1'b0);
        pop();

        // 5: overflow with nine codes, drain in order, clear
        for (int i = 0; i < 9; i++) send(codes[i]);
        settle(6);
        check("t5_count", 32'(fifo_count), 32'(8));
        check("t5_ovf", 32'(overflow), 32'(1));
        for (int i = 0; i < 8; i++) begin
            check("t5_drain_code", 32'(ev_code), 32'(codes[i]));
            pop();
        end
        check("t5_empty", 32'(fifo_count), 32'(0));
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("t5_ovf_cleared", 32'(overflow), 32'(0));

        // 6a: push and pop together while full
        for (int i = 0; i < 8; i++) send(codes[i]);
        fixed_lo = L + 1;
        send_frame(codes[8], 1'b0, 1'b0, 11, c);
        fixed_lo = 0;
        wait_until(c + L + 3);
        check("t6_full_before", 32'(fifo_count), 32'(8));
        ev_ready = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0;
        check("t6_count", 32'(fifo_count), 32'(8));
        check("t6_ovf", 32'(overflow), 32'(0));
        check("t6_head", 32'(ev_code), 32'(codes[1]));
        ev_ready = 1'b1;
        settle(10);
        ev_ready = 1'b0;

        // 6b: reset in the middle of a frame
        send(8'h1C);
        send(8'hF0);
        send_frame(8'h24, 1'b0, 1'b0, 4, c);
        settle(2);
        #3 reset = 1'b1;
        #1;
        check("t6_rst_valid", 32'(ev_valid), 32'(0));
        check("t6_rst_code", 32'(ev_code), 32'(0));
        check("t6_rst_rel", 32'(ev_release), 32'(0));
        check("t6_rst_ext", 32'(ev_extended), 32'(0));
        check("t6_rst_err", 32'(frame_err), 32'(0));
        check("t6_rst_ovf", 32'(overflow), 32'(0));
        check("t6_rst_count", 32'(fifo_count), 32'(0));
        settle(3);
        reset = 1'b0;
        settle(3);
        send(8'h4B);
        expect_head("t6_after_rst", 8'h4B, 1'b0, 1'b0);
        pop();

        // randomized traffic with random consumer and overflow clears
        rnd_done = 1'b0;
        fork
            begin
                logic [7:0] b;
                int r;
                for (int i = 0; i < 60; i++) begin
                    r = int'($urandom_range(9, 0));
                    b = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom);
                    r = int'($urandom_range(9, 0));
                    send_frame(b, r == 0, r == 1, 11, c);
                    settle(int'($urandom_range(20, 0)));
                end
                settle(10);
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(negedge clk);
                    ev_ready = ($urandom_range(199, 0) == 0);
                    clr_ovf  = ($urandom_range(15, 0) == 0);
                end
            end
        join
        ev_ready = 1'b1;
        clr_ovf  = 1'b0;
        settle(12);
        ev_ready = 1'b0;
        check("rnd_drained", 32'(fifo_count), 32'(0));
        settle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_key_event_rx.md
Name: ps2_key_event_rx

Overview:
- PS/2 keyboard receiver, fully synchronous to the system clock. The keyboard clock is oversampled and filtered, never used as a clock.
- Checks start, parity and stop bits, and drops stalled frames on timeout.
- Folds E0/F0 prefixes into one key event: scan code plus release and extended flags.
- Buffers events in a parametrised FWFT FIFO with a valid/ready handshake; sits between the keyboard pins and the scan-code-to-ASCII translation and recorder logic.

Parameters:
- FILTER_LEN, 4: consecutive clk cycles a synchronised kb_clock value must persist before the filtered clock changes (>=1).
- TIMEOUT_CYCLES, 50000: clk cycles without a filtered falling edge, while mid-frame, before the frame is aborted.
- FIFO_DEPTH, 8: event FIFO entries; power of 2, >=2. AW = log2(FIFO_DEPTH).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- kb_clock  in  1  raw PS/2 clock (asynchronous)
- kb_data  in  1  raw PS/2 data (asynchronous)
- ev_ready  in  1  consumer accepts head event
- clr_ovf  in  1  clears overflow
- ev_valid  out  1  FIFO non-empty
- ev_code  out  8  head event scan code
- ev_release  out  1  head event is a break (F0 seen)
- ev_extended  out  1  head event had E0 prefix
- frame_err  out  1  one-cycle pulse on framing, parity or timeout error
- overflow  out  1  sticky: an event was dropped
- fifo_count  out  AW+1  entries held

Behaviour:
- Reset (async, any time, including mid-frame):
  - ev_valid, ev_code, ev_release, ev_extended, frame_err, overflow and fifo_count are all 0.
  - FSM is IDLE; prefix flags are clear; FIFO is emptied.
  - 2-flop synchronisers and the filtered clock reset to 1.
- Input conditioning:
  - kb_clock and kb_data each pass through a 2-flop synchroniser.
  - Filter: a counter increments while sync clock != filtered clock and clears otherwise. On reaching FILTER_LEN, the filtered clock takes the sync value and the counter clears.
  - A fall edge is a one-cycle strobe when the filtered clock goes 1->0. Synced data is sampled in the strobe cycle.
- Frame FSM (one transition per fall edge, except timeout):
  - IDLE: sample 0 -> DATA with bitcnt=0. Sample 1 -> frame_err, stay IDLE.
  - DATA: shift in LSB first; after bit 7 -> PARITY.
  - PARITY: store bit -> STOP.
  - STOP: sample 1 and odd parity (ones in data+parity is odd) -> byte_done, IDLE. Otherwise frame_err, IDLE, byte discarded.
- Timeout:
  - The counter clears on every fall edge and in IDLE; it increments in the other states.
  - At TIMEOUT_CYCLES: frame_err, FSM to IDLE, prefix flags cleared.
- Byte decode, registered on the cycle after byte_done:
  - E0 sets ext. F0 sets rel. Neither is pushed.
  - Any other byte (including E1) is pushed as {code, rel, ext}, then ext and rel clear.
  - Any frame_err also clears ext and rel.
- Latency: the stop bit sampled in the strobe cycle N is written to the FIFO at the end of N+1; ev_valid is visible from N+2 when the FIFO was empty.
- FIFO:
  - FWFT: ev_code, ev_release and ev_extended show the head entry whenever ev_valid=1, and hold their last values otherwise.
  - Pop when ev_valid && ev_ready. Pointers wrap modulo FIFO_DEPTH.
  - Push while full with no pop: event dropped, overflow set.
  - Push and pop in the same cycle while full: both occur, count unchanged, no overflow.
  - Push and pop in the same cycle while empty: only the push occurs.
  - clr_ovf clears overflow; a drop in the same cycle wins, so overflow stays 1.
- frame_err is registered and high for exactly one clk cycle per error event.

Test Plan:
1. Send frame 0x1C with parity 0 and stop 1 -> exactly one event {1C, rel 0, ext 0}; ev_valid 2 cycles after the stop-bit strobe; fifo_count 1, then 0 after an ev_ready pulse.
2. Send bytes F0, 1C -> a single event {1C, rel 1, ext 0}. Send E0, F0, 75 -> {75, rel 1, ext 1}. Send 1C again -> flags clear.
3. Send 0x1C with parity 1 -> frame_err pulses once, no event. Send F0, then a bad-stop frame, then 1C -> event rel 0 (flags cleared by the error).
4. Clock 5 bits, then hold kb_clock high -> frame_err at TIMEOUT_CYCLES, FSM IDLE. A following good 0x15 decodes correctly. Separately, a kb_clock low glitch of FILTER_LEN-1 cycles produces no strobe.
5. Hold ev_ready=0 and send 9 distinct make codes -> fifo_count 8, overflow 1, the ninth code is lost. Draining returns the first 8 in order. clr_ovf -> overflow 0.
6. Full FIFO with ev_ready=1 and a push in the same cycle -> fifo_count stays 8, overflow stays 0. Assert reset mid-frame (after 4 bits) -> all outputs 0; the next full frame decodes cleanly.
